// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator.
// Holds the default 640x480 @ 25 MHz timing set, the derived totals and
// active-area start points, a helper that centres a window in an active
// area, and the struct carried alongside the pixel pipeline.
package vga_pkg;

    // Sync levels and strobes carried through the first pipeline stage.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } sync_t;

    // Offset that centres a window of size win inside an area of size active.
    function automatic int centre_offset(input int active, input int win);
        return (active - win) / 2;
    endfunction

    function automatic int axis_total(input int sync, input int bp,
                                      input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_WIN_W    = 256;
    localparam int DEF_WIN_H    = 256;
    localparam int DEF_WIN_X0   = centre_offset(DEF_H_ACTIVE, DEF_WIN_W);
    localparam int DEF_WIN_Y0   = centre_offset(DEF_V_ACTIVE, DEF_WIN_H);

    localparam int DEF_H_TOT       = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
    localparam int DEF_V_TOT       = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);
    localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo counter for one raster axis.
// Ports: clock, reset (sync, active-high), en (advance), count (current
// position 0..MODULUS-1), wrap (count is at its last value; the next enabled
// clock returns it to 0).
module vga_axis_counter #(
    parameter int MODULUS = 800,
    parameter int W       = $clog2(MODULUS)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    assign wrap = (count == LAST);

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + W'(1);
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with a centred display window.
// A clock-enable divider produces one pixel tick every CLK_DIV clocks; h/v
// counters walk the raster on ticks. Stage 1 issues window-relative pixel
// coordinates to the frame source; stage 2 samples the returned colour one
// tick later, blanks it outside the window and emits it aligned with the
// delayed syncs and line/frame strobes.
// Ports: clock, reset (sync, active-high); i_r/i_g/i_b colour returned for
// the previous request; o_r/o_g/o_b blanked colour; o_hsync/o_vsync syncs
// (asserted level SYNC_POL); o_pix_tick pixel enable; o_win_x/o_win_y/
// o_win_valid window request; o_frame_start/o_line_start one-clock strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int WIN_X0   = DEF_WIN_X0,
    parameter int WIN_W    = DEF_WIN_W,
    parameter int WIN_Y0   = DEF_WIN_Y0,
    parameter int WIN_H    = DEF_WIN_H,
    parameter int COLOR_W  = 1,
    parameter int COORD_W  = 8,
    parameter int SYNC_POL = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COLOR_W-1:0] i_r,
    input  logic [COLOR_W-1:0] i_g,
    input  logic [COLOR_W-1:0] i_b,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_pix_tick,
    output logic [COORD_W-1:0] o_win_x,
    output logic [COORD_W-1:0] o_win_y,
    output logic               o_win_valid,
    output logic               o_frame_start,
    output logic               o_line_start
);
    localparam int   H_TOT = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int   V_TOT = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int   HW    = $clog2(H_TOT);
    localparam int   VW    = $clog2(V_TOT);
    localparam int   DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic POL   = (SYNC_POL != 0);

    // Bounds are one bit wider than the counters so an upper bound equal to
    // the axis total still fits.
    localparam logic [HW:0] HX_LO  = (HW+1)'(H_SYNC + H_BP + WIN_X0);
    localparam logic [HW:0] HX_HI  = (HW+1)'(H_SYNC + H_BP + WIN_X0 + WIN_W);
    localparam logic [HW:0] HS_END = (HW+1)'(H_SYNC);
    localparam logic [VW:0] VY_LO  = (VW+1)'(V_SYNC + V_BP + WIN_Y0);
    localparam logic [VW:0] VY_HI  = (VW+1)'(V_SYNC + V_BP + WIN_Y0 + WIN_H);
    localparam logic [VW:0] VS_END = (VW+1)'(V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam sync_t SYNC_IDLE = '{hsync: !POL, vsync: !POL,
                                    line_start: 1'b0, frame_start: 1'b0};

    logic [DW-1:0] div_cnt;
    logic          pix_tick;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap, v_wrap, in_win;
    logic          frame_top;
    sync_t         s1;
    logic          hs2, vs2, line_q, frame_q;

    // Pixel-rate divider: the tick is registered so it is clean out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            pix_tick <= 1'b1;
        end else begin
            div_cnt  <= div_cnt + DW'(1);
            pix_tick <= 1'b0;
        end
    end

    vga_axis_counter #(.MODULUS(H_TOT), .W(HW)) u_h_cnt (
        .clock (clock),
        .reset (reset),
        .en    (pix_tick),
        .count (h),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.MODULUS(V_TOT), .W(VW)) u_v_cnt (
        .clock (clock),
        .reset (reset),
        .en    (pix_tick & h_wrap),
        .count (v),
        .wrap  (v_wrap)
    );

    assign in_win = ({1'b0, h} >= HX_LO) && ({1'b0, h} < HX_HI) &&
                    ({1'b0, v} >= VY_LO) && ({1'b0, v} < VY_HI);

    // Stage 1: coordinate request plus sync/strobe state for this position.
    // frame_top marks that the counters sit at (0,0): set by reset and by the
    // tick on which both axes wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_win_x     <= '0;
            o_win_y     <= '0;
            o_win_valid <= 1'b0;
            s1          <= SYNC_IDLE;
            frame_top   <= 1'b1;
        end else if (pix_tick) begin
            o_win_valid    <= in_win;
            o_win_x        <= in_win ? COORD_W'(h - HX_LO[HW-1:0]) : '0;
            o_win_y        <= in_win ? COORD_W'(v - VY_LO[VW-1:0]) : '0;
            s1.hsync       <= ({1'b0, h} < HS_END) ? POL : !POL;
            s1.vsync       <= ({1'b0, v} < VS_END) ? POL : !POL;
            s1.line_start  <= (h == '0);
            s1.frame_start <= frame_top;
            frame_top      <= h_wrap & v_wrap;
        end
    end

    // Stage 2: blank the returned colour and align syncs with it. Strobes are
    // high only in the clock right after the stage-2 update.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
            hs2     <= !POL;
            vs2     <= !POL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            line_q  <= pix_tick & s1.line_start;
            frame_q <= pix_tick & s1.frame_start;
            if (pix_tick) begin
                o_r <= o_win_valid ? i_r : '0;
                o_g <= o_win_valid ? i_g : '0;
                o_b <= o_win_valid ? i_b : '0;
                hs2 <= s1.hsync;
                vs2 <= s1.vsync;
            end
        end
    end

    assign o_pix_tick    = pix_tick;
    assign o_hsync       = hs2;
    assign o_vsync       = vs2;
    assign o_line_start  = line_q;
    assign o_frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Three instances run side by side:
// A default 640x480 timing, B a tiny CLK_DIV=1 raster, C an active-high,
// 4-bit colour, CLK_DIV=3 raster. A reference model derives every output
// from the clock count since reset; expectations are queued when stimulus
// is driven and popped one clock later. A and C take a one-clock reset
// mid-frame.
module tb_vga_timing_gen;

    typedef struct {
        int div, hs, hbp, ha, hfp, vs, vbp, va, vfp, wx0, ww, wy0, wh, cw, pol;
    } cfg_t;

    typedef struct {
        int hs, vs, pt, ls, fs, wv, wx, wy, r, g, b;
    } out_t;

    localparam int N_CYC = 6000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst [3];
    logic [3:0] dr [3];
    logic [3:0] dg [3];
    logic [3:0] db [3];

    logic       hs_o [3];
    logic       vs_o [3];
    logic       pt_o [3];
    logic       ls_o [3];
    logic       fs_o [3];
    logic       wv_o [3];
    logic [7:0] wx_o [3];
    logic [7:0] wy_o [3];
    logic       r0, g0, b0, r1, g1, b1;
    logic [3:0] r2, g2, b2;

    vga_timing_gen u_a (
        .clock(clock), .reset(rst[0]),
        .i_r(dr[0][0:0]), .i_g(dg[0][0:0]), .i_b(db[0][0:0]),
        .o_r(r0), .o_g(g0), .o_b(b0),
        .o_hsync(hs_o[0]), .o_vsync(vs_o[0]), .o_pix_tick(pt_o[0]),
        .o_win_x(wx_o[0]), .o_win_y(wy_o[0]), .o_win_valid(wv_o[0]),
        .o_frame_start(fs_o[0]), .o_line_start(ls_o[0])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(4), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .WIN_X0(2), .WIN_W(4), .WIN_Y0(1), .WIN_H(2),
        .COLOR_W(1), .COORD_W(8), .SYNC_POL(0)
    ) u_b (
        .clock(clock), .reset(rst[1]),
        .i_r(dr[1][0:0]), .i_g(dg[1][0:0]), .i_b(db[1][0:0]),
        .o_r(r1), .o_g(g1), .o_b(b1),
        .o_hsync(hs_o[1]), .o_vsync(vs_o[1]), .o_pix_tick(pt_o[1]),
        .o_win_x(wx_o[1]), .o_win_y(wy_o[1]), .o_win_valid(wv_o[1]),
        .o_frame_start(fs_o[1]), .o_line_start(ls_o[1])
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_SYNC(8), .H_BP(4), .H_ACTIVE(16), .H_FP(4),
        .V_SYNC(2), .V_BP(2), .V_ACTIVE(10), .V_FP(2),
        .WIN_X0(4), .WIN_W(8), .WIN_Y0(3), .WIN_H(4),
        .COLOR_W(4), .COORD_W(8), .SYNC_POL(1)
    ) u_c (
        .clock(clock), .reset(rst[2]),
        .i_r(dr[2]), .i_g(dg[2]), .i_b(db[2]),
        .o_r(r2), .o_g(g2), .o_b(b2),
        .o_hsync(hs_o[2]), .o_vsync(vs_o[2]), .o_pix_tick(pt_o[2]),
        .o_win_x(wx_o[2]), .o_win_y(wy_o[2]), .o_win_valid(wv_o[2]),
        .o_frame_start(fs_o[2]), .o_line_start(ls_o[2])
    );

    cfg_t cfg [3];
    int   n_chk = 0;
    int   n_fail = 0;
    out_t sb [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic int htot(input cfg_t k);
        return k.hs + k.hbp + k.ha + k.hfp;
    endfunction

    function automatic int vtot(input cfg_t k);
        return k.vs + k.vbp + k.va + k.vfp;
    endfunction

    // Raster position p (tick index since reset) -> window membership/coords.
    function automatic int win_hit(input cfg_t k, input int p, output int wx, output int wy);
        int h, v;
        h  = p % htot(k);
        v  = (p / htot(k)) % vtot(k);
        wx = h - k.hs - k.hbp - k.wx0;
        wy = v - k.vs - k.vbp - k.wy0;
        return (wx >= 0 && wx < k.ww && wy >= 0 && wy < k.wh) ? 1 : 0;
    endfunction

    // Colour the bench's frame source returns for position p (also outside
    // the window, so blanking is exercised).
    function automatic int pix_base(input cfg_t k, input int p);
        return (p % htot(k)) * 3 + ((p / htot(k)) % vtot(k)) * 5 + 1;
    endfunction

    function automatic out_t model(input cfg_t k, input int c);
        out_t o;
        int m, p, h, v, wx, wy, base, msk;
        o = '{default: 0};
        o.hs = (k.pol == 0) ? 1 : 0;
        o.vs = o.hs;
        if (c == 0) return o;
        msk  = (1 << k.cw) - 1;
        o.pt = (c % k.div == 0) ? 1 : 0;
        m    = (c - 1) / k.div;             // ticks completed
        if (m >= 1) begin
            p = m - 1;
            if (win_hit(k, p, wx, wy) != 0) begin
                o.wv = 1; o.wx = wx; o.wy = wy;
            end
        end
        if (m >= 2) begin
            p = m - 2;
            h = p % htot(k);
            v = (p / htot(k)) % vtot(k);
            o.hs = (h < k.hs) ? k.pol : ((k.pol == 0) ? 1 : 0);
            o.vs = (v < k.vs) ? k.pol : ((k.pol == 0) ? 1 : 0);
            if (win_hit(k, p, wx, wy) != 0) begin
                base = pix_base(k, p);
                o.r  = base & msk;
                o.g  = (k.cw == 4) ? 10 : ((base >> 2) & msk);
                o.b  = (base >> 1) & msk;
            end
            if (((c - 1) % k.div == 0) && (c - 1 >= k.div)) begin
                o.ls = (h == 0) ? 1 : 0;
                o.fs = (h == 0 && v == 0) ? 1 : 0;
            end
        end
        return o;
    endfunction

    task automatic compare_dut(input int d, input out_t e);
        string nm;
        int r, g, b;
        case (d)
            0:       begin nm = "A"; r = int'(r0); g = int'(g0); b = int'(b0); end
            1:       begin nm = "B"; r = int'(r1); g = int'(g1); b = int'(b1); end
            default: begin nm = "C"; r = int'(r2); g = int'(g2); b = int'(b2); end
        endcase
        chk({nm, ".hsync"},       int'(hs_o[d]), e.hs);
        chk({nm, ".vsync"},       int'(vs_o[d]), e.vs);
        chk({nm, ".pix_tick"},    int'(pt_o[d]), e.pt);
        chk({nm, ".line_start"},  int'(ls_o[d]), e.ls);
        chk({nm, ".frame_start"}, int'(fs_o[d]), e.fs);
        chk({nm, ".win_valid"},   int'(wv_o[d]), e.wv);
        chk({nm, ".win_x"},       int'(wx_o[d]), e.wx);
        chk({nm, ".win_y"},       int'(wy_o[d]), e.wy);
        chk({nm, ".r"}, r, e.r);
        chk({nm, ".g"}, g, e.g);
        chk({nm, ".b"}, b, e.b);
    endtask

    initial begin
        int   c [3];
        int   trig [3];
        bit   hit [3];
        int   m, base, msk;
        out_t e;

        cfg[0] = '{div:2, hs:96, hbp:48, ha:640, hfp:16, vs:2, vbp:29, va:480, vfp:10,
                   wx0:192, ww:256, wy0:112, wh:256, cw:1, pol:0};
        cfg[1] = '{div:1, hs:4, hbp:2, ha:8, hfp:2, vs:1, vbp:1, va:4, vfp:1,
                   wx0:2, ww:4, wy0:1, wh:2, cw:1, pol:0};
        cfg[2] = '{div:3, hs:8, hbp:4, ha:16, hfp:4, vs:2, vbp:2, va:10, vfp:2,
                   wx0:4, ww:8, wy0:3, wh:4, cw:4, pol:1};
        // Mid-frame reset points in completed ticks: A at h=500 v=2,
        // C at h=20 v=8 of its second frame.
        trig = '{2100, -1, 788};

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; dr[d] = '0; dg[d] = '0; db[d] = '0;
            c[d] = 0; hit[d] = 1'b0;
        end

        @(negedge clock);
        for (int d = 0; d < 3; d++) sb.push_back(model(cfg[d], 0));

        repeat (N_CYC) begin
            @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                if (sb.size() == 0) chk("scoreboard_empty", 0, 1);
                else begin
                    e = sb.pop_front();
                    compare_dut(d, e);
                end
            end
            for (int d = 0; d < 3; d++) begin
                m = (c[d] >= 1) ? (c[d] - 1) / cfg[d].div : 0;
                rst[d] = 1'b0;
                if (!hit[d] && c[d] >= 1 && m == trig[d]) begin
                    rst[d] = 1'b1;
                    hit[d] = 1'b1;
                end
                // Return the colour for the coordinate currently requested.
                msk = (1 << cfg[d].cw) - 1;
                base = (c[d] >= 1 && m >= 1) ? pix_base(cfg[d], m - 1) : 0;
                dr[d] = 4'(base & msk);
                db[d] = 4'((base >> 1) & msk);
                dg[d] = (cfg[d].cw == 4) ? 4'hA : 4'((base >> 2) & msk);
                c[d] = rst[d] ? 0 : c[d] + 1;
                sb.push_back(model(cfg[d], c[d]));
            end
        end

        for (int d = 0; d < 3; d++) chk("mid_frame_reset_taken", int'(hit[d]), (trig[d] >= 0) ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
